tl_client_arbiter: RTL and testbench

- Shares one TileLink-UL master port between two client ports. Clients are, for example, two buffered DMA/debug initiators feeding a TL buffer toward the system bus.
- Arbitrates the A channel round-robin and locks the grant for multi-beat Put bursts.
- Stamps the 1-bit source with the client index and routes D responses back by source.
- Allows at most one outstanding transaction per client, tracked with busy flags.

---
 rtl/tl_client_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_tl_client_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_client_arbiter.sv
// rtl/tl_client_arbiter.sv - two-client TileLink-UL arbiter: round-robin A grant, burst lock, D routing by source
// Optional feature macro: TLARB_WATCHDOG_EN (adds wdog_err and per-client busy watchdogs)
`timescale 1ns/1ps
module tl_client_arbiter #(
`ifdef TLARB_WATCHDOG_EN
    parameter int WDOG_LIMIT = 1024,
`endif
    parameter int ADDR_W   = 33,
    parameter int DATA_W   = 64,
    parameter int MAX_SIZE = 6
) (
    input  logic              clock,
    input  logic              reset,
`ifdef TLARB_WATCHDOG_EN
    output logic [1:0]        wdog_err,
`endif
    output logic              in0_a_ready,
    input  logic              in0_a_valid,
    input  logic [2:0]        in0_a_bits_opcode,
    input  logic [3:0]        in0_a_bits_size,
    input  logic [ADDR_W-1:0] in0_a_bits_address,
    input  logic [7:0]        in0_a_bits_mask,
    input  logic [DATA_W-1:0] in0_a_bits_data,
    input  logic              in0_d_ready,
    output logic              in0_d_valid,
    output logic [2:0]        in0_d_bits_opcode,
    output logic [3:0]        in0_d_bits_size,
    output logic              in0_d_bits_denied,
    output logic [DATA_W-1:0] in0_d_bits_data,
    output logic              in0_d_bits_corrupt,
    output logic              in1_a_ready,
    input  logic              in1_a_valid,
    input  logic [2:0]        in1_a_bits_opcode,
    input  logic [3:0]        in1_a_bits_size,
    input  logic [ADDR_W-1:0] in1_a_bits_address,
    input  logic [7:0]        in1_a_bits_mask,
    input  logic [DATA_W-1:0] in1_a_bits_data,
    input  logic              in1_d_ready,
    output logic              in1_d_valid,
    output logic [2:0]        in1_d_bits_opcode,
    output logic [3:0]        in1_d_bits_size,
    output logic              in1_d_bits_denied,
    output logic [DATA_W-1:0] in1_d_bits_data,
    output logic              in1_d_bits_corrupt,
    input  logic              out_a_ready,
    output logic              out_a_valid,
    output logic [2:0]        out_a_bits_opcode,
    output logic [2:0]        out_a_bits_param,
    output logic [3:0]        out_a_bits_size,
    output logic              out_a_bits_source,
    output logic [ADDR_W-1:0] out_a_bits_address,
    output logic [7:0]        out_a_bits_mask,
    output logic [DATA_W-1:0] out_a_bits_data,
    output logic              out_a_bits_corrupt,
    output logic              out_d_ready,
    input  logic              out_d_valid,
    input  logic [2:0]        out_d_bits_opcode,
    input  logic [3:0]        out_d_bits_size,
    input  logic              out_d_bits_source,
    input  logic              out_d_bits_denied,
    input  logic [DATA_W-1:0] out_d_bits_data,
    input  logic              out_d_bits_corrupt
);

    // Beat counters must cover every encodable 4-bit size (2^12 beats), since
    // sizes above MAX_SIZE are passed through rather than rejected.
    localparam int CNT_W = (MAX_SIZE - 2 > 13) ? MAX_SIZE - 2 : 13;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t           state;
    logic [1:0]       busy;
    logic [1:0]       busy_next;
    logic             prio;
    logic             lock;
    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] d_cnt;

    logic             elig0;
    logic             elig1;
    logic             gnt;
    logic             gnt_ok;
    logic             a_fire;
    logic             a_data_op;
    logic [CNT_W-1:0] a_beats;
    logic             d_src;
    logic             d_fire;
    logic             d_last;

    function automatic logic [CNT_W-1:0] beats_of(input logic [3:0] size);
        logic [CNT_W-1:0] one;
        one = CNT_W'(1);
        if (size > 4'd3) return one << (size - 4'd3);
        return one;
    endfunction

    // Grant selection: burst lock wins, otherwise round-robin among non-busy valid clients
    always_comb begin
        elig0  = in0_a_valid && !busy[0];
        elig1  = in1_a_valid && !busy[1];
        gnt    = 1'b0;
        gnt_ok = 1'b0;
        if (state == BURST) begin
            gnt    = lock;
            gnt_ok = 1'b1;
        end else begin
            gnt_ok = elig0 || elig1;
            gnt    = (elig0 && elig1) ? prio : elig1;
        end
    end

    assign out_a_valid        = !reset && gnt_ok && (gnt ? in1_a_valid : in0_a_valid);
    assign in0_a_ready        = !reset && gnt_ok && !gnt && out_a_ready;
    assign in1_a_ready        = !reset && gnt_ok &&  gnt && out_a_ready;
    assign out_a_bits_opcode  = gnt ? in1_a_bits_opcode  : in0_a_bits_opcode;
    assign out_a_bits_size    = gnt ? in1_a_bits_size    : in0_a_bits_size;
    assign out_a_bits_address = gnt ? in1_a_bits_address : in0_a_bits_address;
    assign out_a_bits_mask    = gnt ? in1_a_bits_mask    : in0_a_bits_mask;
    assign out_a_bits_data    = gnt ? in1_a_bits_data    : in0_a_bits_data;
    assign out_a_bits_param   = 3'd0;
    assign out_a_bits_source  = gnt;
    assign out_a_bits_corrupt = 1'b0;

    assign a_fire    = out_a_valid && out_a_ready;
    assign a_data_op = (out_a_bits_opcode == 3'd0) || (out_a_bits_opcode == 3'd1);
    assign a_beats   = beats_of(out_a_bits_size);

    assign d_src       = out_d_bits_source;
    assign in0_d_valid = !reset && out_d_valid && !d_src;
    assign in1_d_valid = !reset && out_d_valid &&  d_src;
    assign out_d_ready = !reset && (d_src ? in1_d_ready : in0_d_ready);
    assign d_fire      = out_d_valid && out_d_ready;

    assign in0_d_bits_opcode  = out_d_bits_opcode;
    assign in0_d_bits_size    = out_d_bits_size;
    assign in0_d_bits_denied  = out_d_bits_denied;
    assign in0_d_bits_data    = out_d_bits_data;
    assign in0_d_bits_corrupt = out_d_bits_corrupt;
    assign in1_d_bits_opcode  = out_d_bits_opcode;
    assign in1_d_bits_size    = out_d_bits_size;
    assign in1_d_bits_denied  = out_d_bits_denied;
    assign in1_d_bits_data    = out_d_bits_data;
    assign in1_d_bits_corrupt = out_d_bits_corrupt;

    // Only AccessAckData spans several beats; every other D message ends on its first beat
    always_comb begin
        d_last = 1'b1;
        if (out_d_bits_opcode == 3'd1)
            d_last = (d_cnt + CNT_W'(1)) == beats_of(out_d_bits_size);
    end

    // Busy update: completion clears the responder's flag, a first-beat grant sets the requester's
    always_comb begin
        busy_next = busy;
        if (d_fire && d_last)
            busy_next[d_src] = 1'b0;
        if (a_fire && state == IDLE)
            busy_next[gnt] = 1'b1;
    end

    // A-channel FSM plus busy/priority bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 2'b00;
            prio  <= 1'b0;
            lock  <= 1'b0;
            a_cnt <= '0;
        end else begin
            busy <= busy_next;
            case (state)
                IDLE: begin
                    if (a_fire) begin
                        prio <= ~gnt;
                        if (a_data_op && a_beats > CNT_W'(1)) begin
                            a_cnt <= a_beats - CNT_W'(1);
                            lock  <= gnt;
                            state <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (a_fire) begin
                        a_cnt <= a_cnt - CNT_W'(1);
                        if (a_cnt == CNT_W'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // D beat counter for the message currently returning
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            d_cnt <= '0;
        else if (d_fire)
            d_cnt <= d_last ? '0 : d_cnt + CNT_W'(1);
    end

`ifdef TLARB_WATCHDOG_EN
    logic [15:0] wdog_cnt [2];

    // Per-client age of the outstanding transaction; the error latches until reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_cnt[0] <= 16'd0;
            wdog_cnt[1] <= 16'd0;
            wdog_err    <= 2'b00;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (!busy[n])
                    wdog_cnt[n] <= 16'd0;
                else if (wdog_cnt[n] != 16'hFFFF)
                    wdog_cnt[n] <= wdog_cnt[n] + 16'd1;
                if (busy[n] && (int'(wdog_cnt[n]) + 1 >= WDOG_LIMIT))
                    wdog_err[n] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tl_client_arbiter.sv
// tb/tb_tl_client_arbiter.sv - scoreboard bench for tl_client_arbiter with random and directed traffic
`timescale 1ns/1ps
module tb_tl_client_arbiter;

    localparam int ADDR_W = 33;
    localparam int DATA_W = 64;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [1:0]        a_valid, a_ready, d_ready, d_valid;
    logic [2:0]        a_op   [2];
    logic [3:0]        a_size [2];
    logic [ADDR_W-1:0] a_addr [2];
    logic [7:0]        a_mask [2];
    logic [DATA_W-1:0] a_data [2];
    logic [2:0]        d_op_o   [2];
    logic [3:0]        d_size_o [2];
    logic              d_den_o  [2];
    logic [DATA_W-1:0] d_data_o [2];
    logic              d_cor_o  [2];

    logic              out_a_ready, out_a_valid, out_a_bits_source, out_a_bits_corrupt;
    logic [2:0]        out_a_bits_opcode, out_a_bits_param;
    logic [3:0]        out_a_bits_size;
    logic [ADDR_W-1:0] out_a_bits_address;
    logic [7:0]        out_a_bits_mask;
    logic [DATA_W-1:0] out_a_bits_data;
    logic              out_d_ready, out_d_valid, out_d_bits_source, out_d_bits_denied, out_d_bits_corrupt;
    logic [2:0]        out_d_bits_opcode;
    logic [3:0]        out_d_bits_size;
    logic [DATA_W-1:0] out_d_bits_data;

    tl_client_arbiter dut (
        .clock(clock), .reset(reset),
        .in0_a_ready(a_ready[0]), .in0_a_valid(a_valid[0]), .in0_a_bits_opcode(a_op[0]),
        .in0_a_bits_size(a_size[0]), .in0_a_bits_address(a_addr[0]), .in0_a_bits_mask(a_mask[0]),
        .in0_a_bits_data(a_data[0]), .in0_d_ready(d_ready[0]), .in0_d_valid(d_valid[0]),
        .in0_d_bits_opcode(d_op_o[0]), .in0_d_bits_size(d_size_o[0]), .in0_d_bits_denied(d_den_o[0]),
        .in0_d_bits_data(d_data_o[0]), .in0_d_bits_corrupt(d_cor_o[0]),
        .in1_a_ready(a_ready[1]), .in1_a_valid(a_valid[1]), .in1_a_bits_opcode(a_op[1]),
        .in1_a_bits_size(a_size[1]), .in1_a_bits_address(a_addr[1]), .in1_a_bits_mask(a_mask[1]),
        .in1_a_bits_data(a_data[1]), .in1_d_ready(d_ready[1]), .in1_d_valid(d_valid[1]),
        .in1_d_bits_opcode(d_op_o[1]), .in1_d_bits_size(d_size_o[1]), .in1_d_bits_denied(d_den_o[1]),
        .in1_d_bits_data(d_data_o[1]), .in1_d_bits_corrupt(d_cor_o[1]),
        .out_a_ready(out_a_ready), .out_a_valid(out_a_valid), .out_a_bits_opcode(out_a_bits_opcode),
        .out_a_bits_param(out_a_bits_param), .out_a_bits_size(out_a_bits_size),
        .out_a_bits_source(out_a_bits_source), .out_a_bits_address(out_a_bits_address),
        .out_a_bits_mask(out_a_bits_mask), .out_a_bits_data(out_a_bits_data),
        .out_a_bits_corrupt(out_a_bits_corrupt),
        .out_d_ready(out_d_ready), .out_d_valid(out_d_valid), .out_d_bits_opcode(out_d_bits_opcode),
        .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
        .out_d_bits_denied(out_d_bits_denied), .out_d_bits_data(out_d_bits_data),
        .out_d_bits_corrupt(out_d_bits_corrupt)
    );

    typedef struct {
        bit                src;
        bit [2:0]          op;
        bit [3:0]          size;
        bit [ADDR_W-1:0]   addr;
        bit [7:0]          mask;
        bit [DATA_W-1:0]   data;
    } beat_t;

    typedef struct {
        bit       src;
        bit [2:0] op;
        bit [3:0] size;
    } resp_t;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t exp_q [$];
    beat_t mon_e;
    resp_t resp_q [$];

    // reference state: who is outstanding, whose turn it is, burst remaining
    bit [1:0] m_busy;
    bit       m_prio, m_burst, m_lock;
    int       m_left, m_dcnt;

    // client and responder stimulus state
    bit       c_act [2];
    int       c_left [2];
    resp_t    c_resp [2];
    int       r_cnt;
    bit       rand_on, resp_on, rnd;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int nbeats(input int size);
        return (size > 3) ? (2 ** (size - 3)) : 1;
    endfunction

    // Monitor: every A handshake must match the oldest expected beat
    always @(negedge clock) begin
        if (!reset && out_a_valid && out_a_ready) begin
            if (exp_q.size() == 0) begin
                chk("a_unexpected_beat", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("a_source",  out_a_bits_source,  mon_e.src);
                chk("a_opcode",  out_a_bits_opcode,  mon_e.op);
                chk("a_size",    out_a_bits_size,    mon_e.size);
                chk("a_address", out_a_bits_address, mon_e.addr);
                chk("a_mask",    out_a_bits_mask,    mon_e.mask);
                chk("a_data",    out_a_bits_data,    mon_e.data);
                chk("a_param",   out_a_bits_param,   0);
                chk("a_corrupt", out_a_bits_corrupt, 0);
            end
        end
    end

    task automatic start_txn(input int k, input bit [2:0] op, input bit [3:0] size);
        c_act[k]  = 1'b1;
        a_op[k]   = op;
        a_size[k] = size;
        a_addr[k] = {$urandom, $urandom};
        a_mask[k] = 8'($urandom);
        a_data[k] = {$urandom, $urandom};
        c_left[k] = (op < 2) ? nbeats(size) : 1;
        c_resp[k].src  = k[0];
        c_resp[k].op   = (op < 2) ? 3'd0 : 3'd1;
        c_resp[k].size = size;
    endtask

    task automatic start_rand(input int k);
        bit [2:0] ops [5] = '{3'd0, 3'd1, 3'd4, 3'd2, 3'd3};
        int idx = $urandom_range(4);
        bit [3:0] sz = 4'($urandom_range(7));
        start_txn(k, ops[idx], sz);
    endtask

    task automatic model_reset();
        m_busy = 2'b00; m_prio = 0; m_burst = 0; m_lock = 0; m_left = 0; m_dcnt = 0;
        c_act[0] = 0; c_act[1] = 0; r_cnt = 0;
        resp_q.delete();
        exp_q.delete();
        a_valid = 2'b00;
        out_d_valid = 0;
    endtask

    // Apply this cycle's inputs (one time unit after the edge), then settle
    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            if (rand_on && !c_act[k] && $urandom_range(3) == 0) start_rand(k);
            a_valid[k] = c_act[k];
            if (rnd) d_ready[k] = 1'($urandom_range(1));
        end
        if (rnd) out_a_ready = ($urandom_range(3) != 0);
        if (resp_on && resp_q.size() > 0) begin
            out_d_valid       = rnd ? 1'($urandom_range(1)) : 1'b1;
            out_d_bits_source = resp_q[0].src;
            out_d_bits_opcode = resp_q[0].op;
            out_d_bits_size   = resp_q[0].size;
        end else begin
            out_d_valid = 1'b0;
        end
        out_d_bits_data    = {$urandom, $urandom};
        out_d_bits_denied  = 1'($urandom_range(1));
        out_d_bits_corrupt = 1'($urandom_range(1));
        #1;
    endtask

    // Predict this cycle from the arbitration rules, check, then step past the edge
    task automatic tick();
        bit e0, e1, g, gv, exp_ov, fire, src, dfire;
        bit [1:0] nb;
        beat_t b;
        if (m_burst) begin
            g = m_lock; gv = 1;
        end else begin
            e0 = a_valid[0] && !m_busy[0];
            e1 = a_valid[1] && !m_busy[1];
            gv = e0 || e1;
            g  = (e0 && e1) ? m_prio : e1;
        end
        exp_ov = gv && a_valid[g];
        fire   = exp_ov && out_a_ready;
        chk("out_a_valid", out_a_valid, exp_ov);
        chk("in0_a_ready", a_ready[0], gv && !g && out_a_ready);
        chk("in1_a_ready", a_ready[1], gv &&  g && out_a_ready);
        if (fire) begin
            b.src = g; b.op = a_op[g]; b.size = a_size[g]; b.addr = a_addr[g];
            b.mask = a_mask[g]; b.data = a_data[g];
            exp_q.push_back(b);
        end
        src   = out_d_bits_source;
        dfire = out_d_valid && d_ready[src];
        chk("in0_d_valid", d_valid[0], out_d_valid && !src);
        chk("in1_d_valid", d_valid[1], out_d_valid &&  src);
        chk("out_d_ready", out_d_ready, d_ready[src]);
        if (out_d_valid) begin
            chk("d_data",    d_data_o[src], out_d_bits_data);
            chk("d_opcode",  d_op_o[src],   out_d_bits_opcode);
            chk("d_size",    d_size_o[src], out_d_bits_size);
            chk("d_denied",  d_den_o[src],  out_d_bits_denied);
            chk("d_corrupt", d_cor_o[src],  out_d_bits_corrupt);
        end
        nb = m_busy;
        if (dfire) begin
            m_dcnt++;
            if (out_d_bits_opcode != 3'd1 || m_dcnt == nbeats(out_d_bits_size)) begin
                nb[src] = 0;
                m_dcnt  = 0;
            end
        end
        if (fire) begin
            if (!m_burst) begin
                nb[g]  = 1;
                m_prio = !g;
                if (a_op[g] < 2 && nbeats(a_size[g]) > 1) begin
                    m_burst = 1; m_left = nbeats(a_size[g]) - 1; m_lock = g;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_burst = 0;
            end
        end
        m_busy = nb;
        @(posedge clock);
        #1;
        if (fire) begin
            c_left[g]--;
            if (c_left[g] == 0) begin
                c_act[g] = 0;
                a_valid[g] = 0;
                resp_q.push_back(c_resp[g]);
            end else begin
                a_data[g] = {$urandom, $urandom};
                a_mask[g] = 8'($urandom);
            end
        end
        if (dfire) begin
            r_cnt++;
            if (r_cnt == ((resp_q[0].op == 3'd1) ? nbeats(resp_q[0].size) : 1)) begin
                void'(resp_q.pop_front());
                r_cnt = 0;
            end
        end
    endtask

    task automatic drain(input int n);
        resp_on = 1; out_a_ready = 1; d_ready = 2'b11;
        for (int i = 0; i < n; i++) begin
            drive();
            tick();
        end
    endtask

    initial begin
        int hs;
        reset = 1; rand_on = 0; resp_on = 0; rnd = 0;
        for (int k = 0; k < 2; k++) begin
            a_op[k] = 0; a_size[k] = 0; a_addr[k] = 0; a_mask[k] = 0; a_data[k] = 0;
        end
        model_reset();
        out_d_bits_source = 0; out_d_bits_opcode = 0; out_d_bits_size = 0;
        out_d_bits_data = 0; out_d_bits_denied = 0; out_d_bits_corrupt = 0;
        // reset holds every handshake output low even with active inputs
        a_valid = 2'b11; out_a_ready = 1; d_ready = 2'b11; out_d_valid = 1;
        @(posedge clock); #2;
        chk("rst_out_a_valid", out_a_valid, 0);
        chk("rst_in0_a_ready", a_ready[0], 0);
        chk("rst_in1_a_ready", a_ready[1], 0);
        chk("rst_in0_d_valid", d_valid[0], 0);
        chk("rst_in1_d_valid", d_valid[1], 0);
        chk("rst_out_d_ready", out_d_ready, 0);
        model_reset();
        @(posedge clock); #1;
        reset = 0;

        // both clients Get together: client 0 first, then client 1
        start_txn(0, 3'd4, 4'd3); start_txn(1, 3'd4, 4'd3);
        drive(); chk("t1_first_src", out_a_bits_source, 0); chk("t1_first_valid", out_a_valid, 1); tick();
        drive(); chk("t1_second_src", out_a_bits_source, 1); chk("t1_second_valid", out_a_valid, 1); tick();
        drain(8);

        // 8-beat PutFull from client 0 holds the grant against a waiting Get
        resp_on = 0;
        start_txn(0, 3'd0, 4'd6); start_txn(1, 3'd4, 4'd3);
        for (int i = 0; i < 8; i++) begin
            drive(); chk("t2_burst_src", out_a_bits_source, 0); chk("t2_c1_blocked", a_ready[1], 0); tick();
        end
        drive(); chk("t2_c1_grant_src", out_a_bits_source, 1); chk("t2_c1_ready", a_ready[1], 1); tick();
        drain(16);

        // second Get waits for the first Get's AccessAckData
        resp_on = 0;
        start_txn(0, 3'd4, 4'd3);
        drive(); tick();
        start_txn(0, 3'd4, 4'd3);
        for (int i = 0; i < 3; i++) begin
            drive(); chk("t3_blocked", a_ready[0], 0); tick();
        end
        resp_on = 1;
        drive(); chk("t3_d_valid", d_valid[0], 1); chk("t3_still_busy", a_ready[0], 0); tick();
        drive(); chk("t3_regranted", a_ready[0], 1); tick();
        drain(8);

        // 4-beat AccessAckData to client 1 under toggling d_ready
        resp_on = 0;
        start_txn(1, 3'd4, 4'd5);
        drive(); tick();
        start_txn(1, 3'd4, 4'd3);
        resp_on = 1; d_ready[0] = 1; hs = 0;
        for (int i = 0; i < 8; i++) begin
            d_ready[1] = (i % 2 == 0);
            drive();
            chk("t4_out_d_ready", out_d_ready, (i % 2 == 0));
            chk("t4_in0_d_valid", d_valid[0], 0);
            chk("t4_in1_d_valid", d_valid[1], i < 7);
            chk("t4_busy_gate", a_ready[1], hs == 4);
            tick();
            if (i % 2 == 0 && i < 7) hs++;
        end
        drain(16);

        // asynchronous reset at beat 3 of an 8-beat Put
        resp_on = 0;
        start_txn(0, 3'd0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            drive(); tick();
        end
        drive();
        reset = 1; d_ready = 2'b11;
        #1;
        chk("t5_rst_out_a_valid", out_a_valid, 0);
        chk("t5_rst_in0_a_ready", a_ready[0], 0);
        chk("t5_rst_out_d_ready", out_d_ready, 0);
        model_reset();
        @(posedge clock); #1;
        reset = 0;
        start_txn(0, 3'd4, 4'd3); start_txn(1, 3'd4, 4'd3);
        drive(); chk("t5_prio_reset_src", out_a_bits_source, 0); chk("t5_busy_reset", a_ready[0], 1); tick();
        drive(); chk("t5_c1_src", out_a_bits_source, 1); chk("t5_c1_ready", a_ready[1], 1); tick();
        drain(8);

        // randomized traffic with random back-pressure on both channels
        rnd = 1; rand_on = 1; resp_on = 1;
        for (int i = 0; i < 4000; i++) begin
            drive(); tick();
        end
        rand_on = 0;
        for (int i = 0; i < 400; i++) begin
            drive(); tick();
        end
        rnd = 0;
        drain(100);
        chk("end_exp_q_empty", exp_q.size(), 0);
        chk("end_resp_q_empty", resp_q.size(), 0);
        chk("end_clients_idle", {c_act[1], c_act[0]}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
